// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg
//   Shared types and constants for the register-file writeback arbiter.
//   The width and requester-index macros normally come from the core-wide
//   xgriscv_defines.v. The guarded defaults below keep this slice
//   self-contained. If the shared defines are read first, their values
//   take precedence.
//
//   Macros supplied or expected:
//     XLEN, RFIDX_WIDTH, ADDR_SIZE   datapath widths
//     WBREQ_PIPE/LSU/MDU             requester index constants
//     WBARB_NREQ                     default requester count

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WBREQ_PIPE
`define WBREQ_PIPE 0
`endif
`ifndef WBREQ_LSU
`define WBREQ_LSU 1
`endif
`ifndef WBREQ_MDU
`define WBREQ_MDU 2
`endif
`ifndef WBARB_NREQ
`define WBARB_NREQ 2
`endif

package rf_wb_arbiter_pkg;

  localparam int XLEN_W  = `XLEN;
  localparam int RFIDX_W = `RFIDX_WIDTH;
  localparam int ADDR_W  = `ADDR_SIZE;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 4;

  localparam int STAT_W = 32;

  // Symbolic names for the requester slots. The order fixes the
  // tie-break order right after reset, when the pointer is zero.
  typedef enum logic [1:0] {
    WB_SRC_PIPE = 2'(`WBREQ_PIPE),
    WB_SRC_LSU  = 2'(`WBREQ_LSU),
    WB_SRC_MDU  = 2'(`WBREQ_MDU)
  } wb_src_e;

  // Contents of the single registered output stage.
  typedef struct packed {
    logic               write;
    logic [RFIDX_W-1:0] waddr;
    logic [XLEN_W-1:0]  wdata;
    logic [ADDR_W-1:0]  pc;
  } wb_entry_t;

  // Index of the slot after idx, wrapping modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// rr_arbiter
//   NREQ-wide round-robin priority picker. Scanning starts at ptr and
//   wraps modulo NREQ. The first valid slot found wins. The module holds
//   no state, so the owner keeps and advances the pointer.
//
//   Ports:
//     ptr        in   PTR_W  slot with the highest priority this cycle
//     valid      in   NREQ   request vector
//     grant      out  NREQ   one-hot grant, zero when nothing is valid
//     grant_idx  out  PTR_W  index of the granted slot (0 when none)
//     any        out  1      some slot was granted

module rr_arbiter #(
  parameter  int NREQ  = 2,
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic [NREQ-1:0]  valid,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NREQ);
      if (!any && valid[idx]) begin
        any       = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the single register-file write port between NREQ writeback
//   requesters, for example the pipeline WB stage, the LSU and the MDU.
//   Arbitration is round-robin, and each requester has a valid/ready
//   handshake. The winning write is held in one registered stage that
//   feeds the regfile directly. The regfile captures on the negedge of
//   the same cycle, so this stage drains every cycle and never needs
//   back-pressure. A write to x0 completes its handshake but never
//   raises rf_write.
//
//   Ports:
//     clk        in   1                  core clock
//     reset      in   1                  synchronous, active-high
//     flush      in   1                  kills the output stage, blocks grants
//     req_valid  in   NREQ               per-requester pending write
//     req_ready  out  NREQ               one-hot grant (combinational)
//     req_rd     in   NREQ*RFIDX_WIDTH   packed destination indices
//     req_data   in   NREQ*XLEN          packed write data
//     req_pc     in   NREQ*ADDR_SIZE     packed producer pc
//     rf_write   out  1                  regfile write enable
//     rf_waddr   out  RFIDX_WIDTH        regfile write address
//     rf_wdata   out  XLEN               regfile write data
//     rf_pc      out  ADDR_SIZE          pc for the regfile trace
//     grant_id   out  PTR_W              owner of the current output entry
//   With RF_WB_ARBITER_STATS_EN defined, these ports are added:
//     stat_sel   in   PTR_W              selects a stall counter
//     stat_count out  32                 saturating cycles-waited count

module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter  int NREQ  = `WBARB_NREQ,
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*`RFIDX_WIDTH-1:0]  req_rd,
  input  logic [NREQ*`XLEN-1:0]         req_data,
  input  logic [NREQ*`ADDR_SIZE-1:0]    req_pc,
  output logic                          rf_write,
  output logic [`RFIDX_WIDTH-1:0]       rf_waddr,
  output logic [`XLEN-1:0]              rf_wdata,
  output logic [`ADDR_SIZE-1:0]         rf_pc,
  output logic [PTR_W-1:0]              grant_id
`ifdef RF_WB_ARBITER_STATS_EN
  ,
  input  logic [PTR_W-1:0]              stat_sel,
  output logic [STAT_W-1:0]             stat_count
`endif
);

  logic [PTR_W-1:0]   rr_ptr;
  logic [NREQ-1:0]    arb_grant;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;
  logic               xfer;

  logic [RFIDX_W-1:0] sel_rd;
  logic [XLEN_W-1:0]  sel_data;
  logic [ADDR_W-1:0]  sel_pc;

  wb_entry_t          out_q;
  logic [PTR_W-1:0]   gid_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .ptr       (rr_ptr),
    .valid     (req_valid),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Reset and flush both block the handshake. While reset is high,
  // rr_ptr may still hold an old value, so the grant has to be masked
  // here and not only in the register.
  assign req_ready = (reset || flush) ? '0 : arb_grant;
  assign xfer      = arb_any && !reset && !flush;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    sel_pc   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == PTR_W'(i)) begin
        sel_rd   = req_rd[i*RFIDX_W +: RFIDX_W];
        sel_data = req_data[i*XLEN_W +: XLEN_W];
        sel_pc   = req_pc[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // When no transfer happens, address, data and pc keep their last
  // values. Only the write enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      gid_q  <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      out_q.write <= (sel_rd != '0);
      out_q.waddr <= sel_rd;
      out_q.wdata <= sel_data;
      out_q.pc    <= sel_pc;
      gid_q       <= arb_idx;
      rr_ptr      <= PTR_W'(rr_next(int'(arb_idx), NREQ));
    end else begin
      out_q.write <= 1'b0;
    end
  end

  assign rf_write = out_q.write;
  assign rf_waddr = out_q.waddr;
  assign rf_wdata = out_q.wdata;
  assign rf_pc    = out_q.pc;
  assign grant_id = gid_q;

`ifdef RF_WB_ARBITER_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NREQ];

  // Counts cycles that a requester waits. Flush cycles count as waits
  // because the requester is still holding valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !req_ready[i] && (stat_cnt[i] != '1))
          stat_cnt[i] <= stat_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stat_sel == PTR_W'(i)) stat_count = stat_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int NREQ  = 2;
  localparam int PTR_W = 1;
  localparam int RW    = 5;
  localparam int XW    = 32;
  localparam int AW    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 flush;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*RW-1:0]   req_rd;
  logic [NREQ*XW-1:0]   req_data;
  logic [NREQ*AW-1:0]   req_pc;
  logic                 rf_write;
  logic [RW-1:0]        rf_waddr;
  logic [XW-1:0]        rf_wdata;
  logic [AW-1:0]        rf_pc;
  logic [PTR_W-1:0]     grant_id;
`ifdef RF_WB_ARBITER_STATS_EN
  logic [PTR_W-1:0]     stat_sel;
  logic [31:0]          stat_count;
`endif

  logic [RW-1:0] rd_a   [NREQ];
  logic [XW-1:0] data_a [NREQ];
  logic [AW-1:0] pc_a   [NREQ];

  always_comb begin
    req_rd   = '0;
    req_data = '0;
    req_pc   = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i*RW +: RW]   = rd_a[i];
      req_data[i*XW +: XW] = data_a[i];
      req_pc[i*AW +: AW]   = pc_a[i];
    end
  end

  rf_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_pc    (req_pc),
    .rf_write  (rf_write),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_pc     (rf_pc),
    .grant_id  (grant_id)
`ifdef RF_WB_ARBITER_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_count(stat_count)
`endif
  );

  typedef struct packed {
    logic             w;
    logic [RW-1:0]    a;
    logic [XW-1:0]    d;
    logic [AW-1:0]    pc;
    logic [PTR_W-1:0] g;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int               mptr;
  logic             m_w;
  logic [RW-1:0]    m_a;
  logic [XW-1:0]    m_d;
  logic [AW-1:0]    m_pc;
  logic [PTR_W-1:0] m_g;
  logic [NREQ-1:0]  last_xfer;
  logic [31:0]      m_cnt [NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one clock cycle. It checks the outputs and ready at the negedge,
  // pushes the expected result of the coming posedge, then returns #1
  // after that posedge.
  task automatic tick();
    exp_t            e;
    logic [NREQ-1:0] er;
    int              g;
    int              j;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rf_write", 64'(rf_write), 64'(e.w));
      chk("rf_waddr", 64'(rf_waddr), 64'(e.a));
      chk("rf_wdata", 64'(rf_wdata), 64'(e.d));
      chk("rf_pc",    64'(rf_pc),    64'(e.pc));
      chk("grant_id", 64'(grant_id), 64'(e.g));
    end
    er = '0;
    g  = 0;
    if (!reset && !flush) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (mptr + k) % NREQ;
        if (er == '0 && req_valid[j]) begin
          er[j] = 1'b1;
          g     = j;
        end
      end
    end
    chk("req_ready", 64'(req_ready), 64'(er));
`ifdef RF_WB_ARBITER_STATS_EN
    chk("stat_count", 64'(stat_count), 64'(m_cnt[stat_sel]));
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (reset) m_cnt[i] = '0;
      else if (req_valid[i] && !er[i] && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
    end
    if (reset) begin
      m_w = 1'b0; m_a = '0; m_d = '0; m_pc = '0; m_g = '0; mptr = 0;
    end else if (er != '0) begin
      m_w  = (rd_a[g] != '0);
      m_a  = rd_a[g];
      m_d  = data_a[g];
      m_pc = pc_a[g];
      m_g  = PTR_W'(g);
      mptr = (g + 1) % NREQ;
    end else begin
      m_w = 1'b0;
    end
    e.w = m_w; e.a = m_a; e.d = m_d; e.pc = m_pc; e.g = m_g;
    sb.push_back(e);
    last_xfer = er;
    @(posedge clk);
    #1;
  endtask

  task automatic reload(input int i);
    rd_a[i]   = 5'($urandom_range(1, 31));
    data_a[i] = $urandom;
    pc_a[i]   = 32'h8000_0000 + 32'($urandom_range(0, 1023)) * 4;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    last_xfer = '0;
    mptr      = 0;
    m_w = 1'b0; m_a = '0; m_d = '0; m_pc = '0; m_g = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd_a[i] = '0; data_a[i] = '0; pc_a[i] = '0; m_cnt[i] = '0;
    end
`ifdef RF_WB_ARBITER_STATS_EN
    stat_sel = '0;
`endif

    // reset, then idle
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("idle_write", 64'(rf_write), 64'(0));

    // single requester 0
    rd_a[0] = 5'd5; data_a[0] = 32'hDEAD_BEEF; pc_a[0] = 32'h8000_0010;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("single_write", 64'(rf_write), 64'(1));
    chk("single_waddr", 64'(rf_waddr), 64'(5));
    chk("single_wdata", 64'(rf_wdata), 64'(32'hDEAD_BEEF));
    chk("single_pc",    64'(rf_pc),    64'(32'h8000_0010));
    tick();
    chk("single_drain", 64'(rf_write), 64'(0));
    chk("single_hold",  64'(rf_waddr), 64'(5));

    // both valid from reset: grants alternate 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reload(0); reload(1);
    req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("alt_grant_id", 64'(grant_id), 64'(c % 2));
      for (int i = 0; i < NREQ; i++) if (last_xfer[i]) reload(i);
    end

    // requester 1 writes x0: handshake completes, no regfile write
    req_valid = 2'b10;
    rd_a[1] = '0; data_a[1] = 32'h0000_1234;
    tick();
    chk("x0_write", 64'(rf_write), 64'(0));
    chk("x0_gid",   64'(grant_id), 64'(1));
    reload(0); reload(1);
    req_valid = 2'b11;
    tick();
    chk("x0_ptr_adv", 64'(grant_id), 64'(0));
    reload(0);

    // flush while both requesters are valid
    tick();
    for (int i = 0; i < NREQ; i++) if (last_xfer[i]) reload(i);
    flush = 1'b1;
    tick();
    chk("flush_kill", 64'(rf_write), 64'(0));
    flush = 1'b0;
    tick();
    for (int i = 0; i < NREQ; i++) if (last_xfer[i]) reload(i);
    tick();

    // reset and flush together: reset wins
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    chk("rst_flush_gid", 64'(grant_id), 64'(0));
    chk("rst_flush_pc",  64'(rf_pc),    64'(0));

`ifdef RF_WB_ARBITER_STATS_EN
    req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (last_xfer[i]) reload(i);
    end
    req_valid = 2'b00;
    stat_sel = 1'b0; #1;
    chk("stat_req0", 64'(stat_count), 64'(4));
    stat_sel = 1'b1; #1;
    chk("stat_req1", 64'(stat_count), 64'(4));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("stat_clr1", 64'(stat_count), 64'(0));
    stat_sel = 1'b0; #1;
    chk("stat_clr0", 64'(stat_count), 64'(0));
`endif

    // random traffic with held requests, x0 targets and occasional flush
    req_valid = '0;
    for (int c = 0; c < 80; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (last_xfer[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          reload(i);
          if ($urandom_range(0, 5) == 0) rd_a[i] = '0;
          req_valid[i] = 1'b1;
        end
      end
      flush = ($urandom_range(0, 7) == 0);
    end
    flush = 1'b0;
    req_valid = '0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
